// File: rtl/serialize_word_to_bit_stream.sv
// rtl/serialize_word_to_bit_stream.sv - word-to-serial converter, MSB first, gated by a bit-rate enable
// Optional even-parity bit after each word when SERIALIZE_PARITY_EN is defined.
module serialize_word_to_bit_stream #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up_valid,
    input  logic [W-1:0] up_data,
    output logic         up_ready,
    output logic         a,
    output logic         a_valid
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

`ifdef SERIALIZE_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    logic par;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t        state;
    logic [W-1:0]  sreg;
    logic [CW-1:0] cnt;
    logic          take;

    always_comb begin
        up_ready = 1'b0;
        case (state)
            IDLE:   up_ready = en;
`ifdef SERIALIZE_PARITY_EN
            PARITY: up_ready = en;
`else
            SHIFT:  up_ready = en && (cnt == LAST);
`endif
            default: up_ready = 1'b0;
        endcase
        if (!rst) begin
            up_ready = 1'b0;
        end
    end

    assign take = up_valid && up_ready;

    always_comb begin
        a       = 1'b0;
        a_valid = 1'b0;
        if (state == SHIFT) begin
            a       = sreg[W-1];
            a_valid = 1'b1;
        end
`ifdef SERIALIZE_PARITY_EN
        else if (state == PARITY) begin
            a       = par;
            a_valid = 1'b1;
        end
`endif
    end

    // A transfer always loads from up_data; nothing else ever samples it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
`ifdef SERIALIZE_PARITY_EN
            par   <= 1'b0;
`endif
        end else if (en) begin
            if (take) begin
                state <= SHIFT;
                sreg  <= up_data;
                cnt   <= '0;
`ifdef SERIALIZE_PARITY_EN
                par   <= ^up_data;
`endif
            end else begin
                case (state)
                    SHIFT: begin
                        if (cnt == LAST) begin
`ifdef SERIALIZE_PARITY_EN
                            state <= PARITY;
`else
                            state <= IDLE;
`endif
                            sreg  <= '0;
                            cnt   <= '0;
                        end else begin
                            sreg <= {sreg[W-2:0], 1'b0};
                            cnt  <= cnt + 1'b1;
                        end
                    end
`ifdef SERIALIZE_PARITY_EN
                    PARITY: begin
                        state <= IDLE;
                        par   <= 1'b0;
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/serialize_word_to_bit_stream.md
SERIALIZE_WORD_TO_BIT_STREAM -- requirements
Module: serialize_word_to_bit_stream

Interface
REQ-001 The block SHALL have one parameter: W, default 8, word width in bits (W >= 2).
REQ-002 The block SHALL have port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port: rst  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port: en  input  1  bit-rate enable; the serializer advances only in cycles where en=1.
REQ-005 The block SHALL have port: up_valid  input  1  upstream word available.
REQ-006 The block SHALL have port: up_data  input  W  upstream word, sent MSB first.
REQ-007 The block SHALL have port: up_ready  output  1  block accepts up_data this cycle.
REQ-008 The block SHALL have port: a  output  1  serial bit stream feeding the downstream sequence detector input.
REQ-009 The block SHALL have port: a_valid  output  1  a carries a meaningful bit this cycle.

Function
REQ-010 A word SHALL transfer on a rising edge where up_valid=1 and up_ready=1; up_valid=1 with up_ready=0 SHALL NOT consume a word.
REQ-011 The block SHALL use FSM states IDLE, SHIFT and, only when the Configuration feature is compiled in, PARITY.
REQ-012 In IDLE, up_ready SHALL equal en; on a transfer the FSM SHALL go to SHIFT, load the word into a W-bit shift register and clear a bit counter.
REQ-013 In SHIFT, a SHALL equal the shift register MSB and a_valid SHALL be 1; each cycle with en=1 the register SHALL shift left by one and the counter SHALL increment.
REQ-014 The first bit SHALL appear on a in the cycle after the transfer edge (latency 1); a word with en held 1 SHALL occupy exactly W consecutive cycles on a (W+1 with parity).
REQ-015 On the last data bit (counter = W-1) with parity compiled out, up_ready SHALL equal en; a transfer there SHALL reload and stay in SHIFT (zero-bubble back-to-back); otherwise the FSM SHALL return to IDLE.
REQ-016 In IDLE, a SHALL be 0 and a_valid SHALL be 0.
REQ-017 While en=0, state, counter, shift register, a and a_valid SHALL hold their values and up_ready SHALL be 0.
REQ-018 up_ready SHALL be 0 in SHIFT except on the final bit as defined in REQ-015/REQ-024.
REQ-019 The bit counter SHALL be ceil(log2(W)) bits wide and SHALL never wrap past W-1.
REQ-020 up_data SHALL be sampled only on the transfer edge; later changes SHALL NOT affect the word in flight.

Reset
REQ-021 While rst=0, the FSM SHALL be IDLE, shift register and counter 0, a=0, a_valid=0, up_ready=0, independent of clk.
REQ-022 Reset asserted mid-word SHALL discard the partial word immediately; after release the first transfer SHALL start a fresh word from its MSB.
REQ-023 After rst rises, up_ready SHALL follow REQ-012 from the same cycle.

Configuration
REQ-024 With macro SERIALIZE_PARITY_EN defined, after the last data bit the FSM SHALL enter PARITY for one enabled cycle, driving a = XOR of the W data bits (even parity) with a_valid=1; in PARITY up_ready SHALL equal en and a transfer there SHALL go to SHIFT, otherwise to IDLE; on the last data bit up_ready SHALL be 0.
REQ-025 Without SERIALIZE_PARITY_EN, the PARITY state and parity logic SHALL NOT exist and REQ-015 SHALL apply unchanged.

Verification
REQ-026 W=8, en=1, one word 8'hCC -> a = 1,1,0,0,1,1,0,0 on cycles 1..8 after transfer, a_valid=1 exactly those 8 cycles, then a=0, a_valid=0.
REQ-027 W=8, en=1, up_valid held 1 with 8'hA5 then 8'h3C (parity off) -> 16 contiguous valid bits 1010_0101_0011_1100, second transfer on the 8th bit cycle, no gap.
REQ-028 W=8, en toggling 1,0,1,0,... during 8'hF0 -> each bit held for two cycles, 8 distinct bits 1111_0000 in order, up_ready=0 in every en=0 cycle.
REQ-029 W=8, rst pulsed low for one cycle after 3 bits of 8'hFF -> a=0, a_valid=0 asynchronously; next word 8'h81 emits 1000_0001 in full.
REQ-030 W=8, SERIALIZE_PARITY_EN defined, words 8'h07 then 8'h03 back-to-back -> a = 0000_0111,1,0000_0011,0 (18 contiguous valid bits).
